discharge_pulse_timer: RTL and testbench
========================================

# discharge_pulse_timer

Generates the discharge gate-drive pulse train from the synchronized machining parameters. It sits directly downstream of the SPI-to-sysclk parameter synchronizer and consumes its `is_machine_spi`, `Ton_data`, `Toff_data`, `Ip_data` and `waveform_data` outputs. Its outputs are the MOSFET gate command, the per-pulse current setpoint for the current loop, and pulse-boundary strobes. Parameters are latched only at period boundaries, so an SPI update never produces a malformed pulse.

## Interface
Parameters:
- `TICK_DIV`, default 100: clk cycles per time unit. With a 100 MHz clk, 1 unit = 1 µs.
- `CNT_W`, default 32: width of `pulse_count`.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `is_machine_spi`  in  1: machining enable, already synchronous to `clk`.
- `Ton_data`  in  16: on-time in units. 0 means disabled.
- `Toff_data`  in  16: off-time in units. 0 means disabled.
- `Ip_data`  in  16: peak-current setpoint.
- `waveform_data`  in  16: bit 0 selects mode (0 = continuous, 1 = single-shot). Bits 15:1 are ignored.
- `gate_drive`  out  1: registered MOSFET gate command.
- `pulse_start`  out  1: one-cycle strobe on the first ON cycle.
- `pulse_end`  out  1: one-cycle strobe on the first OFF cycle.
- `ip_setpoint`  out  16: `Ip_data` as latched at pulse start. Held constant through ON and OFF.
- `busy`  out  1: high when state is not IDLE.
- `pulse_count`  out  CNT_W: number of completed ON phases. Wraps modulo 2^CNT_W.

## Operation
- States are IDLE, ON and OFF.
- Reset values: state IDLE; `gate_drive`, `pulse_start`, `pulse_end`, `busy` all 0; `ip_setpoint` 0; `pulse_count` 0; all internal counters 0.
- **IDLE → ON:** taken when `is_machine_spi`=1, `Ton_data`≠0 and `Toff_data`≠0, and an arm flag is set.
  - Ton, Toff, Ip and mode are latched into shadow registers.
  - The prescaler and unit counter are cleared.
- **Arm flag:**
  - Continuous mode: the flag is always set.
  - Single-shot mode: the flag is set by a 0→1 edge of `is_machine_spi` and cleared on entry to ON.
- **ON:** lasts exactly Ton_shadow×TICK_DIV cycles, then the block enters OFF.
- **OFF:** lasts exactly Toff_shadow×TICK_DIV cycles. At the end of OFF:
  - If the ON entry condition holds and mode is continuous, the block relatches all shadow registers and re-enters ON with no gap cycle.
  - Otherwise it returns to IDLE.
- **Stop (`is_machine_spi`=0) during ON:** the ON phase is truncated and the block enters OFF on the next edge. The full Toff_shadow is still enforced as recovery time.
- **Stop during OFF:** OFF completes, then the block returns to IDLE.
- **Parameter changes mid-period:** ignored until the next latch point.
- **Counting:** the prescaler counts 0..TICK_DIV-1 and produces a unit tick. The unit counter is 16 bits, compared against the shadow value, and cannot overflow.
- **`pulse_count`:** increments on every ON→OFF transition, including truncated ones.
- **Zero parameters:** if `Ton_data`=0 or `Toff_data`=0 in IDLE, the block stays IDLE with `gate_drive`=0. The same check applies at an OFF boundary: if either is 0 there, the block goes to IDLE.
- **Reset mid-pulse:** `gate_drive` drops asynchronously to 0 and the block returns to IDLE.

## Timing
- **Start latency:** if the entry condition is true at edge k, then `gate_drive`=1 and `pulse_start`=1 in the cycle after edge k.
- `gate_drive` is high for exactly Ton×TICK_DIV consecutive cycles and low for at least Toff×TICK_DIV cycles. The continuous-mode period is (Ton+Toff)×TICK_DIV.
- `pulse_end` is high in the same cycle that `gate_drive` first reads 0.
- **Truncation latency:** `gate_drive` is low one cycle after the edge at which `is_machine_spi`=0 is sampled.
- `ip_setpoint` updates in the same cycle as `pulse_start`.
- `gate_drive` is a flop output only, to avoid glitches.

## Structure
- Shared package `discharge_pkg` holds:
  - the state enum `pulse_state_t` (IDLE, ON, OFF);
  - mode constants `WAVE_CONT`=0 and `WAVE_SINGLE`=1;
  - the waveform mode bit index.
- Sub-module `unit_tick_gen`: a parameterized prescaler with inputs `clk`, `rst_n`, `clr` and output `tick`. It is reused by other timing blocks in the design.

## Test plan
All scenarios use TICK_DIV=4.
- **Continuous:** Ton=3, Toff=2, Ip=0x1234, mode 0, enable raised → `gate_drive` high 12 cycles, low 8, repeating. `pulse_start` every 20 cycles. `ip_setpoint`=0x1234. `pulse_count` reaches 3 after 3 periods.
- **Mid-period update:** change Ton 3→5 during the first ON → first pulse stays 12 cycles, next pulse is 20 cycles.
- **Truncation:** drop enable 5 cycles into ON → `gate_drive` low one cycle later. OFF lasts 8 cycles, then IDLE. `pulse_count` increments by 1.
- **Single-shot:** mode 1, enable held high → exactly one 12-cycle pulse, then IDLE. A second pulse occurs only after an enable 0→1 edge.
- **Zero guard:** Toff=0 with enable high → the block never leaves IDLE and `gate_drive` stays 0. Setting Toff=2 starts pulsing within 1 cycle.
- **Async reset:** assert `rst_n` mid-ON → `gate_drive` is 0 immediately and all outputs return to their reset values.

Source files
------------

// File: rtl/discharge_pkg.sv
// Shared types and constants for the discharge pulse timing blocks.
package discharge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } pulse_state_t;

  localparam logic WAVE_CONT     = 1'b0;
  localparam logic WAVE_SINGLE   = 1'b1;
  localparam int   WAVE_MODE_BIT = 0;

endpackage

// File: rtl/discharge_pulse_timer_if.sv
// Parameter inputs and pulse outputs of the discharge pulse timer.
interface discharge_pulse_timer_if #(
  parameter int CNT_W = 32
);

  logic             is_machine_spi;
  logic [15:0]      Ton_data;
  logic [15:0]      Toff_data;
  logic [15:0]      Ip_data;
  logic [15:0]      waveform_data;
  logic             gate_drive;
  logic             pulse_start;
  logic             pulse_end;
  logic [15:0]      ip_setpoint;
  logic             busy;
  logic [CNT_W-1:0] pulse_count;

  modport master (
    output is_machine_spi, Ton_data, Toff_data, Ip_data, waveform_data,
    input  gate_drive, pulse_start, pulse_end, ip_setpoint, busy, pulse_count
  );

  modport slave (
    input  is_machine_spi, Ton_data, Toff_data, Ip_data, waveform_data,
    output gate_drive, pulse_start, pulse_end, ip_setpoint, busy, pulse_count
  );

endinterface

// File: rtl/unit_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the last cycle of each time unit.
module unit_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/discharge_pulse_timer.sv
// Discharge gate-drive pulse generator; parameters are shadowed at period boundaries.
module discharge_pulse_timer
  import discharge_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  discharge_pulse_timer_if.slave bus
);

  pulse_state_t state;
  logic [15:0]  ton_q;
  logic [15:0]  toff_q;
  logic [15:0]  unit_cnt;
  logic         mode_q;
  logic         spi_d;
  logic         arm_flag;

  logic tick;
  logic clr;
  logic arm;
  logic entry_ok;
  logic stop;
  logic on_done;
  logic off_done;
  logic start_now;
  logic unused_wave_bits;

  assign unused_wave_bits = ^bus.waveform_data[15:1];

  // Single-shot needs a fresh enable edge; continuous is always armed.
  assign arm       = (bus.waveform_data[WAVE_MODE_BIT] == WAVE_CONT) || arm_flag;
  assign entry_ok  = bus.is_machine_spi && (bus.Ton_data != '0) &&
                     (bus.Toff_data != '0) && arm;
  assign stop      = (state == ON) && !bus.is_machine_spi;
  assign on_done   = (state == ON) && tick && (unit_cnt == ton_q - 16'd1);
  assign off_done  = (state == OFF) && tick && (unit_cnt == toff_q - 16'd1);
  assign start_now = ((state == IDLE) && entry_ok) ||
                     (off_done && entry_ok && (mode_q == WAVE_CONT));
  assign clr       = (state == IDLE) || stop;

  unit_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_unit_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ton_q           <= '0;
      toff_q          <= '0;
      mode_q          <= WAVE_CONT;
      unit_cnt        <= '0;
      spi_d           <= 1'b0;
      arm_flag        <= 1'b0;
      bus.gate_drive  <= 1'b0;
      bus.pulse_start <= 1'b0;
      bus.pulse_end   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.ip_setpoint <= '0;
      bus.pulse_count <= '0;
    end else begin
      spi_d           <= bus.is_machine_spi;
      bus.pulse_start <= 1'b0;
      bus.pulse_end   <= 1'b0;
      if (bus.is_machine_spi && !spi_d) begin
        arm_flag <= 1'b1;
      end

      if (start_now) begin
        // Latch point: later assignments to arm_flag win over the edge set above.
        state           <= ON;
        ton_q           <= bus.Ton_data;
        toff_q          <= bus.Toff_data;
        mode_q          <= bus.waveform_data[WAVE_MODE_BIT];
        bus.ip_setpoint <= bus.Ip_data;
        unit_cnt        <= '0;
        arm_flag        <= 1'b0;
        bus.gate_drive  <= 1'b1;
        bus.pulse_start <= 1'b1;
        bus.busy        <= 1'b1;
      end else begin
        case (state)
          ON: begin
            if (stop || on_done) begin
              state           <= OFF;
              unit_cnt        <= '0;
              bus.gate_drive  <= 1'b0;
              bus.pulse_end   <= 1'b1;
              bus.pulse_count <= bus.pulse_count + CNT_W'(1);
            end else if (tick) begin
              unit_cnt <= unit_cnt + 16'd1;
            end
          end
          OFF: begin
            if (off_done) begin
              state    <= IDLE;
              unit_cnt <= '0;
              bus.busy <= 1'b0;
            end else if (tick) begin
              unit_cnt <= unit_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_discharge_pulse_timer.sv
// Self-checking bench for discharge_pulse_timer with TICK_DIV=4.
module tb_discharge_pulse_timer;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  discharge_pulse_timer_if #(.CNT_W(CNT_W)) bus ();

  discharge_pulse_timer #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        gate;
    logic        start;
    logic        end_p;
    logic        busy;
    logic [15:0] ip;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    bit          rst;
    logic        spi;
    logic [15:0] ton;
    logic [15:0] toff;
    logic [15:0] ip;
    logic [15:0] wf;
    int          cycles;
    obs_t        exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {bus.gate_drive, bus.pulse_start, bus.pulse_end, bus.busy,
         bus.ip_setpoint, bus.pulse_count};
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gate=%0b start=%0b end=%0b busy=%0b ip=%h cnt=%0d, want gate=%0b start=%0b end=%0b busy=%0b ip=%h cnt=%0d",
               name, act.gate, act.start, act.end_p, act.busy, act.ip, act.cnt,
               exp.gate, exp.start, exp.end_p, exp.busy, exp.ip, exp.cnt);
    end
  endtask

  // Expected strobes apply to the first cycle of a phase only.
  function automatic void add(input bit rst, input logic spi, input logic [15:0] ton,
                              input logic [15:0] toff, input logic [15:0] ip,
                              input logic [15:0] wf, input int cycles, input logic gate,
                              input logic start, input logic end_p, input logic busy,
                              input logic [15:0] ip_e, input logic [31:0] cnt_e,
                              input string name);
    vec_t v;
    v.rst    = rst;
    v.spi    = spi;
    v.ton    = ton;
    v.toff   = toff;
    v.ip     = ip;
    v.wf     = wf;
    v.cycles = cycles;
    v.exp    = {gate, start, end_p, busy, ip_e, cnt_e};
    v.name   = name;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic spi, input logic [15:0] ton, input logic [15:0] toff,
                       input logic [15:0] ip, input logic [15:0] wf);
    bus.is_machine_spi = spi;
    bus.Ton_data       = ton;
    bus.Toff_data      = toff;
    bus.Ip_data        = ip;
    bus.waveform_data  = wf;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("reset_values", sample(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    if (v.rst) do_reset();
    drive(v.spi, v.ton, v.toff, v.ip, v.wf);
    for (int i = 0; i < v.cycles; i++) begin
      obs_t e;
      e = v.exp;
      if (i > 0) begin
        e.start = 1'b0;
        e.end_p = 1'b0;
      end
      sb_q.push_back(e);
    end
    for (int i = 0; sb_q.size() > 0; i++) begin
      obs_t e;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("%s[%0d]", v.name, i), sample(), e);
    end
  endtask

  initial begin
    obs_t e;
    drive(1'b0, '0, '0, '0, '0);

    //   rst spi ton    toff   ip        wf        cyc g  s  e  b  ip_e      cnt
    add(1, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE, 12, 1, 1, 0, 1, 16'h1234, 0, "cont_on1");
    add(0, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE,  8, 0, 0, 1, 1, 16'h1234, 1, "cont_off1");
    add(0, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE, 12, 1, 1, 0, 1, 16'h1234, 1, "cont_on2");
    add(0, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE,  8, 0, 0, 1, 1, 16'h1234, 2, "cont_off2");
    add(0, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE, 12, 1, 1, 0, 1, 16'h1234, 2, "cont_on3");
    add(0, 1, 16'd3, 16'd2, 16'h1234, 16'hFFFE,  8, 0, 0, 1, 1, 16'h1234, 3, "cont_off3");

    add(1, 1, 16'd3, 16'd2, 16'h1234, 16'h0000,  5, 1, 1, 0, 1, 16'h1234, 0, "upd_on1a");
    add(0, 1, 16'd5, 16'd2, 16'h5678, 16'h0000,  7, 1, 0, 0, 1, 16'h1234, 0, "upd_on1b");
    add(0, 1, 16'd5, 16'd2, 16'h5678, 16'h0000,  8, 0, 0, 1, 1, 16'h1234, 1, "upd_off1");
    add(0, 1, 16'd5, 16'd2, 16'h5678, 16'h0000, 20, 1, 1, 0, 1, 16'h5678, 1, "upd_on2");
    add(0, 1, 16'd5, 16'd2, 16'h5678, 16'h0000,  8, 0, 0, 1, 1, 16'h5678, 2, "upd_off2");

    add(1, 1, 16'd3, 16'd2, 16'h1234, 16'h0000,  5, 1, 1, 0, 1, 16'h1234, 0, "trunc_on");
    add(0, 0, 16'd3, 16'd2, 16'h1234, 16'h0000,  8, 0, 0, 1, 1, 16'h1234, 1, "trunc_off");
    add(0, 0, 16'd3, 16'd2, 16'h1234, 16'h0000,  4, 0, 0, 0, 0, 16'h1234, 1, "trunc_idle");

    add(1, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001,  1, 0, 0, 0, 0, 16'h0000, 0, "ss_arm");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001, 12, 1, 1, 0, 1, 16'hABCD, 0, "ss_on1");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001,  8, 0, 0, 1, 1, 16'hABCD, 1, "ss_off1");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001,  6, 0, 0, 0, 0, 16'hABCD, 1, "ss_hold");
    add(0, 0, 16'd3, 16'd2, 16'hABCD, 16'h0001,  3, 0, 0, 0, 0, 16'hABCD, 1, "ss_low");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001,  1, 0, 0, 0, 0, 16'hABCD, 1, "ss_rearm");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001, 12, 1, 1, 0, 1, 16'hABCD, 1, "ss_on2");
    add(0, 1, 16'd3, 16'd2, 16'hABCD, 16'h0001,  8, 0, 0, 1, 1, 16'hABCD, 2, "ss_off2");

    add(1, 1, 16'd0, 16'd2, 16'h0042, 16'h0000,  4, 0, 0, 0, 0, 16'h0000, 0, "zero_ton");
    add(0, 1, 16'd3, 16'd0, 16'h0042, 16'h0000,  4, 0, 0, 0, 0, 16'h0000, 0, "zero_toff");
    add(0, 1, 16'd3, 16'd2, 16'h0042, 16'h0000, 12, 1, 1, 0, 1, 16'h0042, 0, "zero_go_on");
    add(0, 1, 16'd3, 16'd2, 16'h0042, 16'h0000,  8, 0, 0, 1, 1, 16'h0042, 1, "zero_go_off");

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset landing mid-cycle during ON, then a clean restart.
    do_reset();
    drive(1'b1, 16'd3, 16'd2, 16'h1234, 16'h0000);
    repeat (6) @(posedge clk);
    #1;
    e = {1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 32'd0};
    check("pre_reset_on", sample(), e);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_on", sample(), '0);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = {1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 32'd0};
    check("restart_after_reset", sample(), e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
